// File: rtl/ib_pkg.sv
// Shared constants, state encoding and lane popcount helper
// for the decoded-instruction buffer controller.
package ib_pkg;

  localparam int INST_QUEUE     = 32;
  localparam int INST_QUEUE_LOG = 5;
  localparam int FETCH_WIDTH    = 8;
  localparam int DISPATCH_WIDTH = 4;
  localparam int FLUSH_CYCLES   = 2;

  localparam int QLOG  = INST_QUEUE_LOG;
  localparam int CNT_W = QLOG + 1;
  localparam int OFS_W = $clog2(FETCH_WIDTH + 1);
  localparam int TMR_W =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } ib_state_t;

  // Number of set bits in vec below lane k.
  function automatic logic [OFS_W-1:0] popcount_prefix(
    input logic [FETCH_WIDTH-1:0] vec,
    input int                     k
  );
    logic [OFS_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (i < k) cnt = cnt + OFS_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ib_lane_compactor.sv
// Maps sparse decode-valid lanes onto contiguous
// write-slot offsets and reports the total slot count.
module ib_lane_compactor
  import ib_pkg::*;
(
  input  logic [FETCH_WIDTH-1:0]       vec_i,
  output logic [FETCH_WIDTH*OFS_W-1:0] offs_o,
  output logic [OFS_W-1:0]             nWr_o
);

  always_comb begin
    offs_o = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      offs_o[k*OFS_W +: OFS_W] = popcount_prefix(vec_i, k);
    end
    nWr_o = popcount_prefix(vec_i, FETCH_WIDTH);
  end

endmodule

// File: rtl/inst_buffer_ctrl.sv
// Head/tail/occupancy sequencer for the decode->rename
// instruction FIFO, with CLEAR/FLUSH/RUN control FSM.
module inst_buffer_ctrl
  import ib_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_i,
  input  logic                            stall_i,
  input  logic                            decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]          decodedVector_i,
  output logic [FETCH_WIDTH-1:0]          wrEn_o,
  output logic [FETCH_WIDTH*QLOG-1:0]     wrAddr_o,
  output logic [DISPATCH_WIDTH*QLOG-1:0]  rdAddr_o,
  output logic                            dispatchValid_o,
  output logic                            stallFetch_o,
  output logic [CNT_W-1:0]                instCount_o,
  output logic                            ramClear_o,
  output logic                            flushBusy_o
);

  ib_state_t        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [QLOG-1:0]  head_q, head_d;
  logic [QLOG-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                      run;
  logic                      wrOK;
  logic [FETCH_WIDTH*OFS_W-1:0] offs;
  logic [OFS_W-1:0]          nVec;
  logic [OFS_W-1:0]          nWr;

  ib_lane_compactor u_compactor (
    .vec_i  (decodedVector_i),
    .offs_o (offs),
    .nWr_o  (nVec)
  );

  assign run = (state_q == RUN);

  assign stallFetch_o = ~run |
    (count_q > CNT_W'(INST_QUEUE - FETCH_WIDTH));

  // A flush in the same cycle suppresses all queue traffic.
  assign wrOK = run & ~flush_i & decodeReady_i
              & ~stallFetch_o;

  assign wrEn_o = {FETCH_WIDTH{wrOK}} & decodedVector_i;
  assign nWr    = wrOK ? nVec : '0;

  assign dispatchValid_o = run & ~flush_i & ~stall_i &
    (count_q >= CNT_W'(DISPATCH_WIDTH));

  assign ramClear_o  = (state_q != RUN);
  assign flushBusy_o = (state_q != RUN);
  assign instCount_o = count_q;

  always_comb begin
    wrAddr_o = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wrAddr_o[k*QLOG +: QLOG] =
        tail_q + QLOG'(offs[k*OFS_W +: OFS_W]);
    end
  end

  always_comb begin
    rdAddr_o = '0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      rdAddr_o[j*QLOG +: QLOG] = head_q + QLOG'(j);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      state_d = FLUSH;
      timer_d = TMR_W'(FLUSH_CYCLES - 1);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        CLEAR: state_d = RUN;
        FLUSH: begin
          if (timer_q == '0) state_d = RUN;
          else timer_d = timer_q - TMR_W'(1);
        end
        RUN: begin
          tail_d = tail_q + QLOG'(nWr);
          if (dispatchValid_o)
            head_d = head_q + QLOG'(DISPATCH_WIDTH);
          count_d = count_q + CNT_W'(nWr)
            - (dispatchValid_o ?
               CNT_W'(DISPATCH_WIDTH) : CNT_W'(0));
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      timer_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Occupancy must agree with the pointer distance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CNT_W'(INST_QUEUE));
      assert (count_q[QLOG-1:0] == QLOG'(tail_q - head_q));
    end
  end

endmodule

// File: tb/tb_inst_buffer_ctrl.sv
// Directed and randomized checks of inst_buffer_ctrl
// against a queue-level reference model.
module tb_inst_buffer_ctrl;

  localparam int Q  = 32;
  localparam int FW = 8;
  localparam int DW = 4;
  localparam int QL = 5;
  localparam int FC = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush_i;
  logic            stall_i;
  logic            decodeReady_i;
  logic [FW-1:0]   vec;
  logic [FW-1:0]   wrEn_o;
  logic [FW*QL-1:0] wrAddr_o;
  logic [DW*QL-1:0] rdAddr_o;
  logic            dispatchValid_o;
  logic            stallFetch_o;
  logic [QL:0]     instCount_o;
  logic            ramClear_o;
  logic            flushBusy_o;

  inst_buffer_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .stall_i         (stall_i),
    .decodeReady_i   (decodeReady_i),
    .decodedVector_i (vec),
    .wrEn_o          (wrEn_o),
    .wrAddr_o        (wrAddr_o),
    .rdAddr_o        (rdAddr_o),
    .dispatchValid_o (dispatchValid_o),
    .stallFetch_o    (stallFetch_o),
    .instCount_o     (instCount_o),
    .ramClear_o      (ramClear_o),
    .flushBusy_o     (flushBusy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model: 0=clear 1=flush 2=run
  int m_state, m_timer, m_head, m_tail, m_count;

  logic [FW-1:0] e_wrEn;
  int            e_addr [FW];
  int            e_rd   [DW];
  int            e_nwr;
  bit            e_dv, e_stall, e_busy;

  function automatic int wa(input int k);
    return int'(wrAddr_o[k*QL +: QL]);
  endfunction

  function automatic int ra(input int j);
    return int'(rdAddr_o[j*QL +: QL]);
  endfunction

  task automatic predict();
    bit run, ok;
    int slot;
    run     = (m_state == 2);
    e_stall = !run || (m_count > Q - FW);
    ok      = run && !flush_i && decodeReady_i && !e_stall;
    e_wrEn  = '0;
    slot    = 0;
    for (int k = 0; k < FW; k++) begin
      e_addr[k] = (m_tail + slot) % Q;
      if (vec[k]) begin
        slot++;
        if (ok) e_wrEn[k] = 1'b1;
      end
    end
    e_nwr  = ok ? slot : 0;
    e_dv   = run && !flush_i && !stall_i && (m_count >= DW);
    for (int j = 0; j < DW; j++) e_rd[j] = (m_head + j) % Q;
    e_busy = (m_state != 2);
  endtask

  task automatic drive(input bit fl, input bit st,
                       input bit rdy, input logic [FW-1:0] v);
    flush_i       = fl;
    stall_i       = st;
    decodeReady_i = rdy;
    vec           = v;
    @(negedge clk);
    predict();
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_timer = 0;
      m_head = 0; m_tail = 0; m_count = 0;
    end else if (flush_i) begin
      m_state = 1; m_timer = FC - 1;
      m_head = 0; m_tail = 0; m_count = 0;
    end else if (m_state == 0) begin
      m_state = 2;
    end else if (m_state == 1) begin
      if (m_timer == 0) m_state = 2;
      else m_timer--;
    end else begin
      m_tail  = (m_tail + e_nwr) % Q;
      m_count = m_count + e_nwr;
      if (e_dv) begin
        m_head  = (m_head + DW) % Q;
        m_count = m_count - DW;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 1, 8'hFF);
    advance();
    drive(0, 0, 1, 8'hFF);
    checks++;
    if (wrEn_o !== 8'h00 || stallFetch_o !== 1'b1 ||
        ramClear_o !== 1'b1 || flushBusy_o !== 1'b1 ||
        dispatchValid_o !== 1'b0 || instCount_o !== 6'd0) begin
      failures++;
      $display("FAIL reset_outs got wrEn=%h stall=%b clr=%b busy=%b dv=%b cnt=%0d want 00 1 1 1 0 0",
               wrEn_o, stallFetch_o, ramClear_o, flushBusy_o,
               dispatchValid_o, instCount_o);
    end
    advance();
    reset = 1'b0;
    drive(0, 1, 0, 8'h00);
    checks++;
    if (ramClear_o !== 1'b1 || flushBusy_o !== 1'b1 ||
        stallFetch_o !== 1'b1) begin
      failures++;
      $display("FAIL clear_cycle got clr=%b busy=%b stall=%b want 1 1 1",
               ramClear_o, flushBusy_o, stallFetch_o);
    end
    advance();
    drive(0, 1, 0, 8'h00);
    checks++;
    if (ramClear_o !== 1'b0 || flushBusy_o !== 1'b0 ||
        stallFetch_o !== 1'b0 || instCount_o !== 6'd0) begin
      failures++;
      $display("FAIL run_entry got clr=%b busy=%b stall=%b cnt=%0d want 0 0 0 0",
               ramClear_o, flushBusy_o, stallFetch_o, instCount_o);
    end
    advance();
  endtask

  task automatic test_sparse_write();
    drive(0, 1, 1, 8'b1010_0101);
    checks++;
    if (wrEn_o !== 8'b1010_0101 || wa(0) != 0 || wa(2) != 1 ||
        wa(5) != 2 || wa(7) != 3 || dispatchValid_o !== 1'b0) begin
      failures++;
      $display("FAIL sparse_write got wrEn=%h a0=%0d a2=%0d a5=%0d a7=%0d dv=%b want a5 0 1 2 3 0",
               wrEn_o, wa(0), wa(2), wa(5), wa(7), dispatchValid_o);
    end
    advance();
    drive(0, 0, 0, 8'h00);
    checks++;
    if (instCount_o !== 6'd4 || dispatchValid_o !== 1'b1 ||
        ra(0) != 0 || ra(1) != 1 || ra(2) != 2 || ra(3) != 3) begin
      failures++;
      $display("FAIL first_dispatch got cnt=%0d dv=%b rd=%0d,%0d,%0d,%0d want 4 1 0,1,2,3",
               instCount_o, dispatchValid_o, ra(0), ra(1), ra(2), ra(3));
    end
    advance();
    drive(0, 1, 0, 8'h00);
    checks++;
    if (instCount_o !== 6'd0 || dispatchValid_o !== 1'b0) begin
      failures++;
      $display("FAIL drained got cnt=%0d dv=%b want 0 0",
               instCount_o, dispatchValid_o);
    end
    advance();
  endtask

  task automatic test_fill();
    int c;
    for (int i = 0; i < 6; i++) begin
      c = (i < 4) ? 8 * i : 32;
      drive(0, 1, 1, 8'hFF);
      checks++;
      if (instCount_o !== 6'(c) ||
          stallFetch_o !== (c > 24) ||
          wrEn_o !== ((c > 24) ? 8'h00 : 8'hFF)) begin
        failures++;
        $display("FAIL fill_%0d got cnt=%0d stall=%b wrEn=%h want %0d %b",
                 i, instCount_o, stallFetch_o, wrEn_o, c, c > 24);
      end
      if (c <= 24) begin
        checks++;
        if (wa(0) != (4 + c) % Q || wa(7) != (11 + c) % Q) begin
          failures++;
          $display("FAIL fill_addr_%0d got a0=%0d a7=%0d want %0d %0d",
                   i, wa(0), wa(7), (4 + c) % Q, (11 + c) % Q);
        end
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    int c, h;
    for (int i = 0; i < 8; i++) begin
      c = 32 - 4 * i;
      h = (4 + 4 * i) % Q;
      drive(0, 0, 0, 8'h00);
      checks++;
      if (instCount_o !== 6'(c) || dispatchValid_o !== 1'b1 ||
          stallFetch_o !== (c > 24) ||
          ra(0) != h || ra(1) != (h + 1) % Q ||
          ra(2) != (h + 2) % Q || ra(3) != (h + 3) % Q) begin
        failures++;
        $display("FAIL wrap_%0d got cnt=%0d dv=%b rd=%0d,%0d,%0d,%0d want cnt %0d head %0d",
                 i, instCount_o, dispatchValid_o,
                 ra(0), ra(1), ra(2), ra(3), c, h);
      end
      advance();
    end
    drive(0, 0, 0, 8'h00);
    checks++;
    if (instCount_o !== 6'd0 || dispatchValid_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_empty got cnt=%0d dv=%b want 0 0",
               instCount_o, dispatchValid_o);
    end
    advance();
  endtask

  task automatic test_flush();
    bit want_busy [5];
    bit want_fl [5];
    want_busy = '{1, 1, 1, 1, 0};
    want_fl   = '{0, 1, 0, 0, 0};
    drive(0, 1, 1, 8'hFF);
    advance();
    drive(1, 0, 1, 8'hFF);
    checks++;
    if (wrEn_o !== 8'h00 || dispatchValid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_gate got wrEn=%h dv=%b want 00 0",
               wrEn_o, dispatchValid_o);
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 8'hFF);
      checks++;
      if (ramClear_o !== 1'b1 || flushBusy_o !== 1'b1 ||
          instCount_o !== 6'd0 || wrEn_o !== 8'h00) begin
        failures++;
        $display("FAIL flush_hold_%0d got clr=%b busy=%b cnt=%0d wrEn=%h want 1 1 0 00",
                 i, ramClear_o, flushBusy_o, instCount_o, wrEn_o);
      end
      advance();
    end
    drive(0, 1, 1, 8'h80);
    checks++;
    if (flushBusy_o !== 1'b0 || wrEn_o !== 8'h80 || wa(7) != 0) begin
      failures++;
      $display("FAIL flush_resume got busy=%b wrEn=%h a7=%0d want 0 80 0",
               flushBusy_o, wrEn_o, wa(7));
    end
    advance();
    drive(1, 1, 0, 8'h00);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(want_fl[i], 1, 0, 8'h00);
      checks++;
      if (flushBusy_o !== want_busy[i]) begin
        failures++;
        $display("FAIL flush_extend_%0d got busy=%b want %b",
                 i, flushBusy_o, want_busy[i]);
      end
      advance();
    end
  endtask

  task automatic test_reset_over_flush();
    reset = 1'b1;
    drive(1, 0, 1, 8'hFF);
    advance();
    reset = 1'b0;
    drive(0, 1, 0, 8'h00);
    advance();
    drive(0, 1, 0, 8'h00);
    checks++;
    if (flushBusy_o !== 1'b0 || instCount_o !== 6'd0) begin
      failures++;
      $display("FAIL reset_over_flush got busy=%b cnt=%0d want 0 0",
               flushBusy_o, instCount_o);
    end
    advance();
  endtask

  task automatic test_random();
    bit bad;
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(99) < 2, $urandom_range(99) < 35,
            $urandom_range(99) < 85, 8'($urandom));
      bad = 0;
      if (wrEn_o !== e_wrEn || dispatchValid_o !== e_dv ||
          stallFetch_o !== e_stall || flushBusy_o !== e_busy ||
          ramClear_o !== e_busy || instCount_o !== 6'(m_count))
        bad = 1;
      for (int k = 0; k < FW; k++)
        if (e_wrEn[k] && wa(k) != e_addr[k]) bad = 1;
      for (int j = 0; j < DW; j++)
        if (ra(j) != e_rd[j]) bad = 1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL random_%0d got wrEn=%h dv=%b stall=%b busy=%b cnt=%0d rd0=%0d want %h %b %b %b %0d %0d",
                 n, wrEn_o, dispatchValid_o, stallFetch_o,
                 flushBusy_o, instCount_o, ra(0),
                 e_wrEn, e_dv, e_stall, e_busy, m_count, e_rd[0]);
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    flush_i = 1'b0;
    stall_i = 1'b0;
    decodeReady_i = 1'b0;
    vec = '0;
    m_state = 0; m_timer = 0;
    m_head = 0; m_tail = 0; m_count = 0;
    test_reset();
    test_sparse_write();
    test_fill();
    test_wrap();
    test_flush();
    test_reset_over_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
